// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU-side, DMA-side and cache-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requester/cache environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_wr;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] cache_addr;
  logic              cache_rd;
  logic              cache_wr;
  logic [DATA_W-1:0] cache_din;
  logic [DATA_W-1:0] cache_dout;
  logic              cache_hit;

  logic              owner;
  logic              busy;
  logic              err;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output cache_addr, cache_rd, cache_wr, cache_din,
    input  cache_dout, cache_hit,
    output owner, busy, err
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  cache_addr, cache_rd, cache_wr, cache_din,
    output cache_dout, cache_hit,
    input  owner, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the cache CPU port between the Mano CPU and a DMA engine, with a watchdog abort.
// Define ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input logic mclk,
  input logic mrst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_t            state_q;
  logic              owner_q;
  logic              wr_q;
  logic              err_q;
  logic              busy_q;
  logic              cpuAck_q;
  logic              dmaAck_q;
  logic              cacheRd_q;
  logic              cacheWr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpuRdata_q;
  logic [DATA_W-1:0] dmaRdata_q;
  logic [7:0]        wdog_q;
  logic [7:0]        wdog_d;
  logic              grantDma_d;
  logic              anyReq;

  always_comb begin
    anyReq = bus.cpu_req | bus.dma_req;
`ifdef ARB_RR_EN
    if (bus.cpu_req && bus.dma_req) begin
      grantDma_d = ~owner_q;
    end else begin
      grantDma_d = bus.dma_req;
    end
`else
    grantDma_d = ~bus.cpu_req;
`endif
    // Saturate so a huge TIMEOUT can never wrap the counter back below it.
    wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b1;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cpuAck_q   <= 1'b0;
      dmaAck_q   <= 1'b0;
      cacheRd_q  <= 1'b0;
      cacheWr_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpuRdata_q <= '0;
      dmaRdata_q <= '0;
      wdog_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            owner_q   <= grantDma_d;
            addr_q    <= grantDma_d ? bus.dma_addr  : bus.cpu_addr;
            wdata_q   <= grantDma_d ? bus.dma_wdata : bus.cpu_wdata;
            wr_q      <= grantDma_d ? bus.dma_wr    : bus.cpu_wr;
            cacheRd_q <= grantDma_d ? ~bus.dma_wr   : ~bus.cpu_wr;
            cacheWr_q <= grantDma_d ? bus.dma_wr    : bus.cpu_wr;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.cache_hit) begin
            // Writers get zero back so stale read data never leaks through an ack.
            if (owner_q) begin
              dmaRdata_q <= wr_q ? '0 : bus.cache_dout;
              dmaAck_q   <= 1'b1;
            end else begin
              cpuRdata_q <= wr_q ? '0 : bus.cache_dout;
              cpuAck_q   <= 1'b1;
            end
            cacheRd_q <= 1'b0;
            cacheWr_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            wdog_q <= wdog_d;
            if (wdog_d >= TimeoutVal) begin
              if (owner_q) begin
                dmaRdata_q <= '0;
                dmaAck_q   <= 1'b1;
              end else begin
                cpuRdata_q <= '0;
                cpuAck_q   <= 1'b1;
              end
              err_q     <= 1'b1;
              cacheRd_q <= 1'b0;
              cacheWr_q <= 1'b0;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          cpuAck_q <= 1'b0;
          dmaAck_q <= 1'b0;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack    = cpuAck_q;
  assign bus.cpu_rdata  = cpuRdata_q;
  assign bus.dma_ack    = dmaAck_q;
  assign bus.dma_rdata  = dmaRdata_q;
  assign bus.cache_addr = addr_q;
  assign bus.cache_din  = wdata_q;
  assign bus.cache_rd   = cacheRd_q;
  assign bus.cache_wr   = cacheWr_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 64).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic mclk;
  logic mrst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  mem_port_arbiter #(.TIMEOUT(64), .ADDR_W(12), .DATA_W(16)) dut (
    .mclk (mclk),
    .mrst (mrst),
    .bus  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic cReq, input logic cWr, input logic [11:0] cAddr, input logic [15:0] cWdata,
    input logic dReq, input logic dWr, input logic [11:0] dAddr, input logic [15:0] dWdata,
    input logic hit, input logic [15:0] dout
  );
    bus.cpu_req    = cReq;
    bus.cpu_wr     = cWr;
    bus.cpu_addr   = cAddr;
    bus.cpu_wdata  = cWdata;
    bus.dma_req    = dReq;
    bus.dma_wr     = dWr;
    bus.dma_addr   = dAddr;
    bus.dma_wdata  = dWdata;
    bus.cache_hit  = hit;
    bus.cache_dout = dout;
  endtask

  logic expOrder [4];
  logic seenOrder [4];
  int   grants;
  int   bothAcks;
  int   strobeCycles;
  int   overlapStrobes;

  initial begin
    checks = 0;
    errors = 0;
    mrst   = 1'b1;
    applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 16'h0000);
    repeat (2) @(negedge mclk);

    checkOutput("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    checkOutput("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    checkOutput("rst_strobes", 32'({bus.cache_rd, bus.cache_wr}), 32'd0);
    checkOutput("rst_busy_err", 32'({bus.busy, bus.err}), 32'd0);
    checkOutput("rst_owner", 32'(bus.owner), 32'd1);
    checkOutput("rst_addr_din", {4'd0, bus.cache_addr, bus.cache_din}, 32'd0);
    checkOutput("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 32'd0);
    mrst = 1'b0;

    // CPU read hitting in its first ACCESS cycle.
    applyStimulus(1, 0, 12'h012, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 16'hBEEF);
    @(negedge mclk);
    checkOutput("rd_strobe", 32'({bus.cache_rd, bus.cache_wr}), 32'd2);
    checkOutput("rd_addr", 32'(bus.cache_addr), 32'h012);
    checkOutput("rd_owner_busy", 32'({bus.owner, bus.busy}), 32'd1);
    checkOutput("rd_no_ack_yet", 32'(bus.cpu_ack), 32'd0);
    @(negedge mclk);
    checkOutput("rd_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd2);
    checkOutput("rd_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
    checkOutput("rd_err", 32'(bus.err), 32'd0);
    checkOutput("rd_strobe_off", 32'({bus.cache_rd, bus.cache_wr}), 32'd0);
    applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 16'h0000);
    @(negedge mclk);
    checkOutput("rd_idle", 32'({bus.cpu_ack, bus.busy}), 32'd0);

    // DMA write with the cache completing after five ACCESS cycles.
    applyStimulus(0, 0, 12'h000, 16'h0000, 1, 1, 12'hFFF, 16'h1234, 0, 16'h7777);
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      checkOutput($sformatf("wr_strobe_%0d", i), 32'({bus.cache_rd, bus.cache_wr}), 32'd1);
      checkOutput($sformatf("wr_bus_%0d", i), {4'd0, bus.cache_addr, bus.cache_din}, 32'h0FFF1234);
      checkOutput($sformatf("wr_no_ack_%0d", i), 32'(bus.dma_ack), 32'd0);
      if (i == 4) begin
        bus.cache_hit = 1'b1;
        bus.dma_req   = 1'b0;
      end
    end
    @(negedge mclk);
    checkOutput("wr_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd1);
    checkOutput("wr_rdata", 32'(bus.dma_rdata), 32'd0);
    checkOutput("wr_owner", 32'(bus.owner), 32'd1);
    checkOutput("wr_strobe_off", 32'({bus.cache_rd, bus.cache_wr}), 32'd0);
    bus.cache_hit = 1'b0;
    @(negedge mclk);
    checkOutput("wr_idle", 32'(bus.busy), 32'd0);

    // Both sides requesting continuously; last grantee was DMA.
`ifdef ARB_RR_EN
    expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    applyStimulus(1, 0, 12'h111, 16'h0000, 1, 0, 12'h222, 16'h0000, 1, 16'hA5A5);
    grants   = 0;
    bothAcks = 0;
    overlapStrobes = 0;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      @(negedge mclk);
      if (bus.cpu_ack && bus.dma_ack) bothAcks++;
      if (bus.cache_rd && bus.cache_wr) overlapStrobes++;
      if (bus.cache_rd) begin
        seenOrder[grants] = bus.owner;
        checkOutput($sformatf("rr_addr_%0d", grants), 32'(bus.cache_addr),
                    expOrder[grants] ? 32'h222 : 32'h111);
        grants++;
      end
    end
    checkOutput("rr_grants", 32'(grants), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_order_%0d", i), 32'(seenOrder[i]), 32'(expOrder[i]));
    end
    applyStimulus(0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 16'hA5A5);
    @(negedge mclk);
    checkOutput("rr_last_ack", 32'({bus.cpu_ack, bus.dma_ack}), expOrder[3] ? 32'd1 : 32'd2);
    checkOutput("rr_last_rdata", 32'(expOrder[3] ? bus.dma_rdata : bus.cpu_rdata), 32'hA5A5);
    if (bus.cpu_ack && bus.dma_ack) bothAcks++;
    @(negedge mclk);
    checkOutput("rr_idle", 32'(bus.busy), 32'd0);
    checkOutput("rr_both_acks", 32'(bothAcks), 32'd0);
    checkOutput("rr_both_strobes", 32'(overlapStrobes), 32'd0);

    // CPU read that never completes: watchdog abort.
    applyStimulus(1, 0, 12'h055, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 16'hFFFF);
    strobeCycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge mclk);
      if (bus.cache_rd) strobeCycles++;
      else if (strobeCycles > 0) break;
    end
    checkOutput("to_strobe_cycles", 32'(strobeCycles), 32'd64);
    checkOutput("to_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd2);
    checkOutput("to_err", 32'(bus.err), 32'd1);
    checkOutput("to_rdata", 32'(bus.cpu_rdata), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge mclk);
    checkOutput("to_idle", 32'({bus.busy, bus.err, bus.cpu_ack}), 32'd0);

    // Reset pulsed in the third ACCESS cycle of a DMA read.
    applyStimulus(0, 0, 12'h000, 16'h0000, 1, 0, 12'h333, 16'h0000, 0, 16'h0000);
    repeat (3) @(negedge mclk);
    checkOutput("mr_active", 32'({bus.cache_rd, bus.owner}), 32'd3);
    mrst = 1'b1;
    bus.dma_req = 1'b0;
    @(negedge mclk);
    mrst = 1'b0;
    checkOutput("mr_strobes", 32'({bus.cache_rd, bus.cache_wr}), 32'd0);
    checkOutput("mr_no_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
    checkOutput("mr_owner", 32'(bus.owner), 32'd1);
    @(negedge mclk);
    checkOutput("mr_still_no_ack", 32'({bus.dma_ack, bus.busy}), 32'd0);
    applyStimulus(1, 0, 12'h0AB, 16'h0000, 0, 0, 12'h000, 16'h0000, 1, 16'h5A5A);
    @(negedge mclk);
    checkOutput("mr_cpu_addr", {4'd0, bus.cache_addr, 15'd0, bus.owner}, {4'd0, 12'h0AB, 16'd0});
    bus.cpu_req = 1'b0;
    @(negedge mclk);
    checkOutput("mr_cpu_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd2);
    checkOutput("mr_cpu_rdata", 32'(bus.cpu_rdata), 32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single CPU-side port of the 256x16 direct-mapped cache (and through it the 4096x16 main memory) between the Mano CPU datapath and a DMA/IO engine. It accepts request/acknowledge transactions from each side, serialises them onto the cache port, holds the read/write strobe until the cache reports completion via `cache_hit`, and returns read data with a one-cycle acknowledge. A watchdog aborts accesses that never complete.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum ACCESS cycles without `cache_hit` before abort (legal range 1..255).
- `ADDR_W`, 12: word-address width.
- `DATA_W`, 16: data width.

Ports:
- `mclk`  in  1  system clock; all state updates on rising edge.
- `mrst`  in  1  reset, synchronous, active-high.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_wr`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to CPU.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ack`.
- `dma_req`, `dma_wr`, `dma_addr`, `dma_wdata`  in  1/1/ADDR_W/DATA_W  DMA request, same rules as CPU.
- `dma_ack`, `dma_rdata`  out  1/DATA_W  DMA completion and read data.
- `cache_addr`  out  ADDR_W  to cache `cpu_addr`.
- `cache_rd`, `cache_wr`  out  1  to cache `cpu_rd` / `cpu_wr`.
- `cache_din`  out  DATA_W  to cache `cpu_din`.
- `cache_dout`  in  DATA_W  from cache `cpu_dout`.
- `cache_hit`  in  1  access complete (hit, or miss fill finished).
- `owner`  out  1  0 = CPU, 1 = DMA; current/last grantee.
- `busy`  out  1  high in ACCESS and DONE.
- `err`  out  1  high with the ack of a timed-out access.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any `*_req` high at the edge, select winner (see Configuration), latch winner's addr, wr, wdata into internal registers, set `owner`, clear watchdog, go ACCESS. No request: stay IDLE.
- ACCESS: `cache_addr`/`cache_din` driven from latched registers; `cache_rd` = !wr, `cache_wr` = wr. Strobe stays asserted every ACCESS cycle. On edge with `cache_hit`=1: register `cache_dout` into winner's rdata, go DONE. Otherwise increment watchdog; when it reaches `TIMEOUT`, go DONE with err flag set and rdata = 0.
- DONE: strobes low; winner's `*_ack` = 1, `err` = flag; the other ack stays 0. Next edge: IDLE.
- Requesters drop `*_req` on the edge ending their ack cycle; a request still high in IDLE is a new transaction.
- Requester inputs are ignored outside IDLE; changes during ACCESS do not reach the cache.
- Write: rdata of writer is 0 at ack.
- Never both acks high; never `cache_rd` and `cache_wr` together.

## Timing
- Reset: state IDLE; all acks, strobes, `err`, `busy` = 0; `cache_addr`, `cache_din`, rdata = 0; `owner` = 1 (DMA last, so CPU wins first tie); watchdog = 0.
- `mrst` mid-transaction: strobes drop on that edge, no ack issued, transaction lost.
- Minimum latency: req sampled at edge 0 → ACCESS cycle 1; hit in cycle 1 → ack in cycle 2 → IDLE cycle 3. Back-to-back grant earliest at edge ending cycle 3.
- Miss: ack arrives one cycle after the cycle `cache_hit` is first seen high.
- Timeout: ack with `err`=1 in cycle `TIMEOUT`+1 after grant.
- Watchdog 8-bit, saturating; never wraps.

## Configuration
- `ARB_RR_EN` defined: round-robin; on simultaneous requests the side not equal to `owner` wins; single request always wins.
- `ARB_RR_EN` undefined: fixed priority, CPU always beats DMA; `owner` still reports grantee. DMA may starve by design.

## Test plan
- CPU read, addr 0x012, `cache_hit` in first ACCESS cycle, `cache_dout`=0xBEEF → `cache_rd`=1 for one cycle, `cpu_ack`=1 two cycles after req sample, `cpu_rdata`=0xBEEF, `err`=0.
- DMA write addr 0xFFF data 0x1234, `cache_hit` delayed 5 cycles → `cache_wr` held 5 cycles with `cache_din`=0x1234, `dma_ack` next cycle, `dma_rdata`=0.
- Both requesting continuously, 4 transactions, `ARB_RR_EN` defined → grant order CPU, DMA, CPU, DMA; undefined → CPU ×4.
- `cache_hit` never asserted, `TIMEOUT`=64 → strobe for 64 cycles, ack with `err`=1, rdata=0, then IDLE.
- `mrst` pulsed in third ACCESS cycle → strobes 0 next cycle, no ack, `owner`=1, following CPU request served normally.
